// File: rtl/run_step_sequencer_pkg.sv
// Shared types and phase constants for the run/step execution sequencer.
package run_step_pkg;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    RUN,
    STEP,
    HALTED
  } state_e;

  localparam logic [2:0] PH_NONE = 3'd0;
  localparam logic [2:0] PH_1    = 3'd1;
  localparam logic [2:0] PH_2    = 3'd2;
  localparam logic [2:0] PH_3    = 3'd3;
  localparam logic [2:0] PH_4    = 3'd4;
  localparam logic [2:0] PH_5    = 3'd5;

  localparam logic [2:0] LAST_PHASE = PH_5;

endpackage

// File: rtl/run_step_sequencer_btn_edge_sync.sv
// Front-panel button synchronizer followed by a rising-edge detector:
// one single-cycle pulse per press, nothing while the button is held.
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/run_step_sequencer.sv
// Run/step execution controller sequencing phase strobes p1..p5.
// Optional break-on-count stop is enabled with `define RUN_STEP_BREAK_COUNT_EN.
module run_step_sequencer
  import run_step_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter int         COUNT_W        = 16,
  parameter logic [4:0] MEM_PHASE_MASK = 5'b01001
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               exec_btn,
  input  logic               step_btn,
  input  logic               mem_ready,
  input  logic               halt_req,
`ifdef RUN_STEP_BREAK_COUNT_EN
  input  logic               break_en,
  input  logic [COUNT_W-1:0] break_value,
`endif
  output logic [2:0]         phase,
  output logic               p1,
  output logic               p2,
  output logic               p3,
  output logic               p4,
  output logic               p5,
  output logic               register_reset,
  output logic               running,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  logic exec_p;
  logic step_p;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_exec_sync (
    .clock (clock),
    .reset (reset),
    .btn   (exec_btn),
    .pulse (exec_p)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clock (clock),
    .reset (reset),
    .btn   (step_btn),
    .pulse (step_p)
  );

  state_e             state_q,          state_d;
  logic [2:0]         phase_q,          phase_d;
  logic [4:0]         p_q,              p_d;
  logic               register_reset_q, register_reset_d;
  logic               running_q,        running_d;
  logic               halted_q,         halted_d;
  logic               stop_pending_q,   stop_pending_d;
  logic [COUNT_W-1:0] instr_count_q,    instr_count_d;

  logic               mem_phase;
  logic               phase_done;
  logic               break_hit;
  logic [COUNT_W-1:0] count_inc;

  // p_q is the one-hot copy of phase_q, so it doubles as the mask selector.
  assign mem_phase  = |(MEM_PHASE_MASK & p_q);
  assign phase_done = (|p_q) && (!mem_phase || mem_ready);
  assign count_inc  = instr_count_q + COUNT_W'(1);

`ifdef RUN_STEP_BREAK_COUNT_EN
  assign break_hit = (state_q == RUN) && break_en && (count_inc == break_value);
`else
  assign break_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= CLR;
      phase_q          <= PH_NONE;
      p_q              <= '0;
      register_reset_q <= 1'b1;
      running_q        <= 1'b0;
      halted_q         <= 1'b0;
      stop_pending_q   <= 1'b0;
      instr_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      phase_q          <= phase_d;
      p_q              <= p_d;
      register_reset_q <= register_reset_d;
      running_q        <= running_d;
      halted_q         <= halted_d;
      stop_pending_q   <= stop_pending_d;
      instr_count_q    <= instr_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    stop_pending_d = stop_pending_q;
    instr_count_d  = instr_count_q;
    case (state_q)
      CLR: state_d = IDLE;
      IDLE: begin
        if (exec_p) begin
          state_d = RUN;
          phase_d = PH_1;
        end else if (step_p) begin
          state_d = STEP;
          phase_d = PH_1;
        end
      end
      RUN, STEP: begin
        if (state_q == RUN && exec_p) begin
          stop_pending_d = 1'b1;
        end
        if (phase_done) begin
          if (phase_q != LAST_PHASE) begin
            phase_d = phase_q + 3'd1;
          end else begin
            // Retirement: a stop request seen in this same cycle still counts.
            instr_count_d = count_inc;
            if (halt_req) begin
              state_d        = HALTED;
              phase_d        = PH_NONE;
              stop_pending_d = 1'b0;
            end else if (state_q == RUN && !stop_pending_d && !break_hit) begin
              phase_d = PH_1;
            end else begin
              state_d        = IDLE;
              phase_d        = PH_NONE;
              stop_pending_d = 1'b0;
            end
          end
        end
      end
      HALTED: state_d = HALTED;
      default: begin
        state_d        = CLR;
        phase_d        = PH_NONE;
        stop_pending_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    register_reset_d = (state_d == CLR);
    running_d        = (state_d == RUN);
    halted_d         = (state_d == HALTED);
    p_d              = '0;
    for (int k = 1; k <= 5; k++) begin
      p_d[k-1] = (phase_d == 3'(k));
    end
  end

  assign phase          = phase_q;
  assign p1             = p_q[0];
  assign p2             = p_q[1];
  assign p3             = p_q[2];
  assign p4             = p_q[3];
  assign p5             = p_q[4];
  assign register_reset = register_reset_q;
  assign running        = running_q;
  assign halted         = halted_q;
  assign instr_count    = instr_count_q;

endmodule

// File: tb/tb_run_step_sequencer.sv
// Directed self-checking bench for run_step_sequencer (COUNT_W overridden to 4).
module tb_run_step_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          exec_btn;
  logic          step_btn;
  logic          mem_ready;
  logic          halt_req;
`ifdef RUN_STEP_BREAK_COUNT_EN
  logic          break_en;
  logic [CW-1:0] break_value;
`endif
  logic [2:0]    phase;
  logic          p1, p2, p3, p4, p5;
  logic          register_reset;
  logic          running;
  logic          halted;
  logic [CW-1:0] instr_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  run_step_sequencer #(
    .SYNC_STAGES    (2),
    .COUNT_W        (CW),
    .MEM_PHASE_MASK (5'b01001)
  ) dut (
    .clock          (clk),
    .reset          (reset),
    .exec_btn       (exec_btn),
    .step_btn       (step_btn),
    .mem_ready      (mem_ready),
    .halt_req       (halt_req),
`ifdef RUN_STEP_BREAK_COUNT_EN
    .break_en       (break_en),
    .break_value    (break_value),
`endif
    .phase          (phase),
    .p1             (p1),
    .p2             (p2),
    .p3             (p3),
    .p4             (p4),
    .p5             (p5),
    .register_reset (register_reset),
    .running        (running),
    .halted         (halted),
    .instr_count    (instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_phase(input logic [2:0] ph, input int bound, input string tag);
    int n = 0;
    while (phase !== ph && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(phase), 32'(ph));
  endtask

  task automatic chk_strobes(input string tag, input logic [2:0] ph);
    logic [4:0] exp_s;
    exp_s = (ph == 3'd0) ? 5'b00000 : (5'b00001 << (ph - 3'd1));
    chk(tag, 32'({p5, p4, p3, p2, p1}), 32'(exp_s));
  endtask

  initial begin
    reset = 1'b1; exec_btn = 1'b0; step_btn = 1'b0; mem_ready = 1'b1; halt_req = 1'b0;
`ifdef RUN_STEP_BREAK_COUNT_EN
    break_en = 1'b0; break_value = '0;
`endif
    repeat (3) tick();
    chk("rst_phase", 32'(phase), 0);
    chk("rst_regrst", 32'(register_reset), 1);
    chk("rst_running", 32'(running), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_count", 32'(instr_count), 0);
    chk_strobes("rst_strobes", 3'd0);

    // Release reset just after an edge: CLR must last exactly one cycle.
    @(posedge clk); #1 reset = 1'b0;
    tick();
    chk("clr_regrst", 32'(register_reset), 1);
    tick();
    chk("idle_regrst", 32'(register_reset), 0);
    chk("idle_phase", 32'(phase), 0);
    chk("idle_count", 32'(instr_count), 0);

    // Single step with memory always ready.
    step_btn = 1'b1;
    wait_phase(3'd1, 8, "step_start");
    chk_strobes("step_s1", 3'd1);
    chk("step_running", 32'(running), 0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("step_phase", 32'(phase), 32'(k));
      chk_strobes("step_strobe", 3'(k));
    end
    tick();
    chk("step_end_phase", 32'(phase), 0);
    chk("step_end_count", 32'(instr_count), 1);
    repeat (8) tick();
    chk("held_phase", 32'(phase), 0);
    chk("held_count", 32'(instr_count), 1);
    step_btn = 1'b0;
    repeat (3) tick();

    // Run with memory stalls in phases 1 and 4.
    mem_ready = 1'b0;
    exec_btn = 1'b1;
    wait_phase(3'd1, 8, "run_start");
    exec_btn = 1'b0;
    chk("run_running", 32'(running), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_p1", 32'(phase), 1);
    end
    mem_ready = 1'b1;
    tick();
    chk("adv_p2", 32'(phase), 2);
    mem_ready = 1'b0;
    tick();
    chk("nowait_p3", 32'(phase), 3);
    tick();
    chk("enter_p4", 32'(phase), 4);
    tick();
    chk("stall_p4a", 32'(phase), 4);
    tick();
    chk("stall_p4b", 32'(phase), 4);
    mem_ready = 1'b1;
    tick();
    chk("adv_p5", 32'(phase), 5);
    tick();
    chk("loop_p1", 32'(phase), 1);
    chk("loop_count", 32'(instr_count), 2);
    chk("loop_running", 32'(running), 1);

    // Stop requested during phase 2 of instruction 3.
    tick();
    chk("stop_p2", 32'(phase), 2);
    exec_btn = 1'b1;
    tick(); tick(); tick();
    chk("stop_p5", 32'(phase), 5);
    chk("stop_p5_running", 32'(running), 1);
    tick();
    chk("stop_phase", 32'(phase), 0);
    chk("stop_running", 32'(running), 0);
    chk("stop_count", 32'(instr_count), 3);
    exec_btn = 1'b0;
    repeat (4) tick();

    // Two stop presses in one instruction must not cancel each other.
    mem_ready = 1'b0;
    exec_btn = 1'b1;
    wait_phase(3'd1, 8, "dbl_start");
    exec_btn = 1'b0; repeat (4) tick();
    exec_btn = 1'b1; repeat (4) tick();
    exec_btn = 1'b0; repeat (4) tick();
    exec_btn = 1'b1; repeat (4) tick();
    exec_btn = 1'b0;
    chk("dbl_stalled", 32'(phase), 1);
    mem_ready = 1'b1;
    wait_phase(3'd5, 8, "dbl_p5");
    tick();
    chk("dbl_phase", 32'(phase), 0);
    chk("dbl_running", 32'(running), 0);
    chk("dbl_count", 32'(instr_count), 4);
    repeat (4) tick();

    // Halt during phase 5 with a stop pending; halt_req held high throughout.
    mem_ready = 1'b0;
    exec_btn = 1'b1;
    wait_phase(3'd1, 8, "halt_start");
    exec_btn = 1'b0; repeat (4) tick();
    exec_btn = 1'b1; repeat (4) tick();
    exec_btn = 1'b0;
    halt_req = 1'b1;
    mem_ready = 1'b1;
    wait_phase(3'd5, 8, "halt_p5");
    tick();
    chk("halt_halted", 32'(halted), 1);
    chk("halt_phase", 32'(phase), 0);
    chk("halt_running", 32'(running), 0);
    chk("halt_count", 32'(instr_count), 5);
    halt_req = 1'b0;
    exec_btn = 1'b1;
    step_btn = 1'b1;
    repeat (6) tick();
    chk("halt_ignore_phase", 32'(phase), 0);
    chk("halt_ignore_halted", 32'(halted), 1);
    exec_btn = 1'b0;
    step_btn = 1'b0;
    repeat (2) tick();

    // Asynchronous reset out of HALTED.
    reset = 1'b1;
    #1;
    chk("arst_regrst", 32'(register_reset), 1);
    chk("arst_halted", 32'(halted), 0);
    chk("arst_count", 32'(instr_count), 0);
    @(posedge clk); #1 reset = 1'b0;
    tick();
    chk("arst_clr", 32'(register_reset), 1);
    tick();
    chk("arst_idle", 32'(register_reset), 0);

    // Counter wrap with COUNT_W=4.
    exec_btn = 1'b1;
    wait_phase(3'd1, 8, "wrap_start");
    exec_btn = 1'b0;
    for (int n = 0; n < 200 && instr_count !== 4'hF; n++) tick();
    chk("wrap_15", 32'(instr_count), 15);
    wait_phase(3'd5, 8, "wrap_p5");
    tick();
    chk("wrap_zero", 32'(instr_count), 0);
    chk("wrap_continue", 32'(phase), 1);
    exec_btn = 1'b1;
    for (int n = 0; n < 20 && running !== 1'b0; n++) tick();
    chk("wrap_stop_running", 32'(running), 0);
    chk("wrap_stop_phase", 32'(phase), 0);
    exec_btn = 1'b0;
    repeat (4) tick();

`ifdef RUN_STEP_BREAK_COUNT_EN
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    break_en = 1'b1;
    break_value = 4'd3;
    repeat (3) tick();
    exec_btn = 1'b1;
    wait_phase(3'd1, 8, "brk_start");
    exec_btn = 1'b0;
    for (int n = 0; n < 60 && running !== 1'b0; n++) tick();
    chk("brk_running", 32'(running), 0);
    chk("brk_phase", 32'(phase), 0);
    chk("brk_count", 32'(instr_count), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
